// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// controller state encoding and iteration-counter sizing.
package div_pkg;

  localparam int DIV_N = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic int cnt_width(input int n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring divider datapath on operand magnitudes, with operand registers,
// iteration counter and the final sign-fix of quotient and remainder.
module div_datapath
  import div_pkg::*;
#(
  parameter int W = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*W-1:0] d_i,
  input  logic           dwrite_i,
  input  logic [W-1:0]   v_i,
  input  logic           vwrite_i,
  input  logic           wr_en_i,
  input  logic           clr_i,
  input  logic           zero_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           fix_i,
  output logic [2*W-1:0] quotient_o,
  output logic [W-1:0]   remainder_o,
  output logic           div_by_zero_o,
  output logic           overflow_o,
  output logic           count_zero_o,
  output logic           divisor_zero_o
);

  localparam int CW = cnt_width(W);

  logic [2*W-1:0] d_q, q_q, quo_q;
  logic [W-1:0]   v_q, mv_q, rem_q;
  logic [W:0]     p_q;
  logic [CW-1:0]  cnt_q;
  logic           dbz_q, ovf_q;

  logic [2*W-1:0] mag_d, q_d, q_neg;
  logic [W-1:0]   mag_v, r_neg;
  logic [W:0]     p_sh, p_d;
  logic [W+1:0]   trial;

  // Magnitudes are unsigned, so the most-negative operand keeps its value.
  assign mag_d = d_q[2*W-1] ? ('0 - d_q) : d_q;
  assign mag_v = v_q[W-1]   ? ('0 - v_q) : v_q;

  always_comb begin
    p_sh  = {p_q[W-1:0], q_q[2*W-1]};
    trial = {1'b0, p_sh} - {2'b00, mv_q};
    if (!trial[W+1]) begin
      p_d = trial[W:0];
      q_d = {q_q[2*W-2:0], 1'b1};
    end else begin
      p_d = p_sh;
      q_d = {q_q[2*W-2:0], 1'b0};
    end
  end

  assign q_neg = '0 - q_q;
  assign r_neg = '0 - p_q[W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q   <= '0;
      v_q   <= '0;
      q_q   <= '0;
      mv_q  <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en_i && dwrite_i) d_q <= d_i;
      if (wr_en_i && vwrite_i) v_q <= v_i;
      if (clr_i) begin
        dbz_q <= 1'b0;
        ovf_q <= 1'b0;
      end
      if (zero_i) begin
        quo_q <= '0;
        rem_q <= '0;
        dbz_q <= 1'b1;
      end
      if (load_i) begin
        q_q   <= mag_d;
        mv_q  <= mag_v;
        p_q   <= '0;
        cnt_q <= CW'(2 * W);
      end
      if (step_i) begin
        p_q   <= p_d;
        q_q   <= q_d;
        cnt_q <= cnt_q - CW'(1);
      end
      if (fix_i) begin
        quo_q <= (d_q[2*W-1] ^ v_q[W-1]) ? q_neg : q_q;
        rem_q <= d_q[2*W-1] ? r_neg : p_q[W-1:0];
        ovf_q <= (d_q == {1'b1, {(2*W-1){1'b0}}}) && (v_q == '1);
      end
    end
  end

  // Flags the step that brings the counter to zero, so ITER exits without an idle cycle.
  assign count_zero_o   = (cnt_q == CW'(1));
  assign divisor_zero_o = (v_q == '0);
  assign quotient_o     = quo_q;
  assign remainder_o    = rem_q;
  assign div_by_zero_o  = dbz_q;
  assign overflow_o     = ovf_q;

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider (2N / N): host protocol with operand write
// strobes, start and level done; controller FSM driving div_datapath.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*N-1:0] D,
  input  logic           Dwrite,
  input  logic [N-1:0]   V,
  input  logic           Vwrite,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Quotient,
  output logic [N-1:0]   Remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  logic [2:0] state_q, state_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       clr, zero, load, step, fix;
  logic       count_zero, divisor_zero;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    clr     = 1'b0;
    zero    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_INIT;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          clr     = 1'b1;
        end else if (state_q == S_DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      S_INIT: begin
        if (divisor_zero) begin
          zero    = 1'b1;
          state_d = S_DONE;
        end else begin
          load    = 1'b1;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        step = 1'b1;
        if (count_zero) state_d = S_FIX;
      end
      S_FIX: begin
        fix     = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  div_datapath #(.W(N)) u_dp (
    .clk            (clk),
    .rst_n          (rst_n),
    .d_i            (D),
    .dwrite_i       (Dwrite),
    .v_i            (V),
    .vwrite_i       (Vwrite),
    .wr_en_i        (!busy_q),
    .clr_i          (clr),
    .zero_i         (zero),
    .load_i         (load),
    .step_i         (step),
    .fix_i          (fix),
    .quotient_o     (Quotient),
    .remainder_o    (Remainder),
    .div_by_zero_o  (div_by_zero),
    .overflow_o     (overflow),
    .count_zero_o   (count_zero),
    .divisor_zero_o (divisor_zero)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: directed protocol cases plus a random
// regression checked against an integer-arithmetic reference model.
module tb_seq_signed_divider;

  localparam int N  = 8;
  localparam int W2 = 2 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W2-1:0] D = '0;
  logic          Dwrite = 1'b0;
  logic [N-1:0]  V = '0;
  logic          Vwrite = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, div_by_zero, overflow;
  logic [W2-1:0] Quotient;
  logic [N-1:0]  Remainder;

  int npass = 0;
  int ntot  = 0;

  seq_signed_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .Dwrite(Dwrite), .V(V), .Vwrite(Vwrite),
    .start(start), .busy(busy), .done(done), .Quotient(Quotient),
    .Remainder(Remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed integer division, truncating toward zero.
  task automatic model(input logic [W2-1:0] d, input logic [N-1:0] v,
                       output logic [W2-1:0] q, output logic [N-1:0] r,
                       output logic dz, output logic ov);
    int di, vi, qi, ri;
    di = int'($signed(d));
    vi = int'($signed(v));
    if (vi == 0) begin
      q = '0; r = '0; dz = 1'b1; ov = 1'b0;
    end else begin
      qi = di / vi;
      ri = di % vi;
      q  = qi[W2-1:0];
      r  = ri[N-1:0];
      dz = 1'b0;
      ov = (di == -(1 <<< (W2 - 1))) && (vi == -1);
    end
  endtask

  // Launch an operation (optionally writing operands) and wait for done.
  task automatic run_op(input logic wr, input logic [W2-1:0] d, input logic [N-1:0] v,
                        output int lat, output logic busy_ok);
    D = d; V = v; Dwrite = wr; Vwrite = wr; start = 1'b1;
    tick();
    Dwrite = 1'b0; Vwrite = 1'b0; start = 1'b0;
    lat = -1;
    busy_ok = busy;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic check_op(input string tag, input logic [W2-1:0] d, input logic [N-1:0] v,
                          input int lat);
    logic [W2-1:0] eq;
    logic [N-1:0]  er;
    logic          edz, eov;
    int            prod, rv, vv;
    model(d, v, eq, er, edz, eov);
    chk({tag, "_lat"}, lat, edz ? 2 : 19);
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
    chk({tag, "_dz"}, div_by_zero, edz);
    chk({tag, "_ov"}, overflow, eov);
    chk({tag, "_busy_low"}, busy, 1'b0);
    if (!edz) begin
      vv   = int'($signed(v));
      rv   = int'($signed(Remainder));
      prod = int'($signed(Quotient)) * vv + rv;
      chk({tag, "_ident"}, prod[W2-1:0], d);
      chk({tag, "_rmag"}, ((rv < 0 ? -rv : rv) < (vv < 0 ? -vv : vv)), 1'b1);
      chk({tag, "_rsign"}, (rv == 0) || ((rv < 0) == d[W2-1]), 1'b1);
    end
  endtask

  initial begin
    int lat;
    logic bok;
    logic [W2-1:0] rd;
    logic [N-1:0]  rvv;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", Quotient, 16'h0000);
    chk("rst_r", Remainder, 8'h00);
    chk("rst_flags", {div_by_zero, overflow}, 2'b00);
    rst_n = 1'b1;
    tick();

    // Basic positive case with busy window
    run_op(1'b1, 16'd100, 8'd7, lat, bok);
    chk("pos_busy_window", bok, 1'b1);
    chk("pos_q_const", Quotient, 16'h000E);
    chk("pos_r_const", Remainder, 8'h02);
    check_op("pos", 16'd100, 8'd7, lat);

    run_op(1'b1, 16'hFF9C, 8'd7, lat, bok);
    chk("negd_q_const", Quotient, 16'hFFF2);
    chk("negd_r_const", Remainder, 8'hFE);
    check_op("negd", 16'hFF9C, 8'd7, lat);

    run_op(1'b1, 16'd100, 8'hF9, lat, bok);
    chk("negv_q_const", Quotient, 16'hFFF2);
    chk("negv_r_const", Remainder, 8'h02);
    check_op("negv", 16'd100, 8'hF9, lat);

    // Divide by zero, then a valid op clears the flag
    run_op(1'b1, 16'h1234, 8'h00, lat, bok);
    chk("dz_lat_const", lat, 2);
    check_op("dz", 16'h1234, 8'h00, lat);
    run_op(1'b1, 16'd50, 8'd5, lat, bok);
    check_op("dz_clear", 16'd50, 8'd5, lat);

    // Most-negative dividend cases
    run_op(1'b1, 16'h8000, 8'hFF, lat, bok);
    chk("ovf_flag_const", overflow, 1'b1);
    chk("ovf_q_const", Quotient, 16'h8000);
    check_op("ovf", 16'h8000, 8'hFF, lat);
    run_op(1'b1, 16'h8000, 8'h80, lat, bok);
    chk("minmin_q_const", Quotient, 16'h0100);
    check_op("minmin", 16'h8000, 8'h80, lat);

    // Write and start while busy are ignored
    D = 16'd500; V = 8'd3; Dwrite = 1'b1; Vwrite = 1'b1; start = 1'b1;
    tick();
    Dwrite = 1'b0; Vwrite = 1'b0; start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 6) begin D = 16'd9; Dwrite = 1'b1; start = 1'b1; end
      if (i == 7) begin Dwrite = 1'b0; start = 1'b0; end
      tick();
      if (done) begin lat = i; break; end
    end
    Dwrite = 1'b0; start = 1'b0;
    chk("busywr_q_const", Quotient, 16'd166);
    chk("busywr_r_const", Remainder, 8'd2);
    check_op("busywr", 16'd500, 8'd3, lat);
    run_op(1'b0, 16'd9, 8'd0, lat, bok);
    check_op("held_ops", 16'd500, 8'd3, lat);

    // Reset mid-operation
    D = 16'd1000; V = 8'd7; Dwrite = 1'b1; Vwrite = 1'b1; start = 1'b1;
    tick();
    Dwrite = 1'b0; Vwrite = 1'b0; start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_q", Quotient, 16'h0000);
    chk("midrst_r", Remainder, 8'h00);
    chk("midrst_flags", {div_by_zero, overflow}, 2'b00);
    rst_n = 1'b1;
    tick();
    // Operands were cleared: a bare start sees divisor 0
    run_op(1'b0, 16'h0000, 8'h00, lat, bok);
    check_op("postrst", 16'h0000, 8'h00, lat);

    // Random regression
    for (int k = 0; k < 2000; k++) begin
      rd  = W2'($urandom);
      rvv = N'($urandom);
      case (k % 50)
        0: begin rd = 16'h8000; rvv = 8'hFF; end
        1: rvv = 8'h00;
        2: rvv = 8'h80;
        3: rd = 16'h8000;
        4: rvv = 8'h01;
        default: ;
      endcase
      run_op(1'b1, rd, rvv, lat, bok);
      check_op("rand", rd, rvv, lat);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multi-cycle signed divider: 2N-bit dividend / N-bit divisor, returning a 2N-bit quotient and an N-bit remainder.
- Inverse companion of the team's Booth multiplier. Same host-side protocol: operand write strobes, start, done.
- Internally a controller FSM plus a restoring shift/subtract datapath on operand magnitudes, with a sign-fix step at the end.

Parameters:
- N, 8, divisor/remainder width. Dividend and quotient are 2N bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- D  input  2N  dividend, two's complement
- Dwrite  input  1  load D into dividend operand register
- V  input  N  divisor, two's complement
- Vwrite  input  1  load V into divisor operand register
- start  input  1  begin division on held operands
- busy  output  1  high from accepted start until done rises
- done  output  1  result valid; level signal
- Quotient  output  2N  signed quotient, truncated toward zero
- Remainder  output  N  signed remainder; carries the sign of the dividend
- div_by_zero  output  1  divisor was 0 for this operation
- overflow  output  1  quotient not representable (most-negative dividend / -1)

Behaviour:
- Reset (rst_n=0 at a clk edge): operand registers, Quotient, Remainder, flags, busy and done all go to 0; FSM goes to IDLE. Reset mid-operation aborts at once with no partial result.
- Operand writes:
  - Dwrite/Vwrite take effect only when busy=0.
  - Writes while busy are ignored.
  - A write in the same cycle as an accepted start is applied first; start uses the new value.
- FSM states: IDLE, INIT, ITER, FIX, DONE.
  - IDLE/DONE with start=1 -> INIT. Clears done and both flags; sets busy.
  - INIT:
    - If divisor==0: Quotient=0, Remainder=0, div_by_zero=1 -> DONE.
    - Otherwise: load |dividend| into the 2N-bit quotient shift register, |divisor| into an N-bit magnitude register, partial remainder P(N+1 bits)=0, count=2N -> ITER.
  - ITER, once per cycle:
    - Shift {P,Q} left by 1.
    - T = P - |V|. If T>=0: P=T and Q[0]=1. Else P unchanged and Q[0]=0.
    - Decrement count; leave when count reaches 0 -> FIX.
  - FIX:
    - Quotient = sign(D) xor sign(V) ? -Q : Q.
    - Remainder = sign(D) ? -P : P.
    - overflow=1 iff D = -2^(2N-1) and V = -1; Quotient is then 2^(2N-1) (e.g. 0x8000), and that bit pattern is what is driven.
    - -> DONE.
  - DONE: done=1, busy=0. Outputs hold until the next accepted start or reset.
- Latency from the edge sampling start:
  - Normal: 2N+3 edges to done=1 (19 for N=8).
  - Divide-by-zero: 2 edges.
- Start handling:
  - start while busy is ignored.
  - start held continuously re-triggers on each DONE visit. The host pulses start.
- Magnitude of the most-negative operand is taken as an unsigned (2N or N)-bit value. No sign loss.
- Invariants, whenever done=1 and div_by_zero=0:
  - |Remainder| < |V|
  - Quotient*V + Remainder == D, computed in 3N-bit arithmetic; holds modulo 2^(2N) when overflow=1.

Decomposition:
- Shared package div_pkg: N default, FSM state encoding (IDLE, INIT, ITER, FIX, DONE), counter width clog2(2N)+1.
- Sub-module div_datapath: operand registers, magnitude/negate logic, P/Q shift registers, subtractor, counter, sign-fix.
  - Inputs: controller strobes.
  - Outputs: count_zero and divisor_zero status.
- FSM lives in seq_signed_divider.

Test Plan:
- D=100 (0x0064), V=7, start pulse -> done rises 19 cycles later; Quotient=0x000E, Remainder=0x02, flags 0; busy high for cycles 1..18.
- D=-100 (0xFF9C), V=7 -> Quotient=0xFFF2 (-14), Remainder=0xFE (-2). D=100, V=-7 (0xF9) -> Quotient=0xFFF2, Remainder=0x02.
- D=0x1234, V=0 -> done after 2 cycles, div_by_zero=1, Quotient=0, Remainder=0. The next valid op clears div_by_zero.
- D=0x8000, V=0xFF -> overflow=1, Quotient=0x8000, Remainder=0. D=0x8000, V=0x80 -> Quotient=0x0100, Remainder=0, overflow=0.
- Start D=500, V=3; at cycle 6 pulse Dwrite with D=9 and pulse start -> both ignored, result Quotient=166, Remainder=2. Then rst_n=0 at cycle 10 of the next op -> all outputs 0 next edge, FSM IDLE.
- Random regression: 2000 random D/V pairs -> check the identity and remainder-sign invariants against a reference model.
